// File: rtl/fpmul_norm_ctrl.sv
// fpmul_norm_ctrl: normalize/round sequencing controller for the FP32
// multiplier back end. Takes the raw 48-bit mantissa product, biased exponent
// sum and sign, normalizes with a leading-zero count and left shift, rounds to
// nearest-even, re-normalizes on rounding carry, and packs an IEEE-754 single.
// Overflow saturates to Inf; underflow flushes to signed zero.
// Optional macro FPMUL_STATUS_EN adds o_flags = {inexact, overflow, underflow, zero}.
module fpmul_norm_ctrl #(
    parameter int MAN_W = 23,
    parameter int EXP_W = 10,
    parameter int EMAX  = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [2*(MAN_W+1)-1:0]   i_prod,
    input  logic [EXP_W-1:0]         i_exp,
    input  logic                     i_sign,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [31:0]              o_result
`ifdef FPMUL_STATUS_EN
    ,
    output logic [3:0]               o_flags
`endif
);

    localparam int PW    = 2 * (MAN_W + 1);
    localparam int CNT_W = $clog2(PW + 1);
    localparam logic [EXP_W-1:0] EMAX_V   = EXP_W'(EMAX);
    localparam logic [EXP_W-1:0] EXP_ZERO = '0;

    typedef enum logic [2:0] {IDLE, NORM, ROUND, RENORM, DONE} state_t;

    state_t             state, state_d;
    logic [PW-1:0]      prod_q;
    logic [EXP_W-1:0]   exp_q;
    logic               sign_q;
    logic               zero_q;
    logic               accept;
    logic               load_res;
    logic [CNT_W-1:0]   cnt;
    logic [MAN_W-1:0]   man_w;
    logic [MAN_W-1:0]   man_rnd;
    logic               guard_b;
    logic               sticky_b;
    logic               round_up;
    logic               carry;
    logic [EXP_W-1:0]   fin_exp;
    logic [MAN_W-1:0]   fin_man;
    logic               ovf;
    logic               unf;
    logic [31:0]        res_d;
`ifdef FPMUL_STATUS_EN
    logic               gs_q;
    logic               fin_inexact;
    logic [3:0]         flags_d;
`endif

    // Leading-zero count; the highest set bit is the last one the loop sees.
    function automatic logic [CNT_W-1:0] lzc(input logic [PW-1:0] v);
        lzc = CNT_W'(PW);
        for (int i = 0; i < PW; i++) begin
            if (v[i]) lzc = CNT_W'(PW - 1 - i);
        end
    endfunction

    assign o_ready  = (state == IDLE);
    assign accept   = i_valid && o_ready;
    assign cnt      = lzc(prod_q);

    // Rounding fields taken from the normalized product (leading one at bit PW-1).
    assign man_w    = prod_q[PW-2 -: MAN_W];
    assign guard_b  = prod_q[PW-2-MAN_W];
    assign sticky_b = |prod_q[PW-3-MAN_W:0];
    assign round_up = guard_b & (sticky_b | man_w[0]);
    assign man_rnd  = man_w + MAN_W'(round_up);
    assign carry    = round_up & (&man_w);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_d;
    end

    // Next-state logic and selection of the final exponent/mantissa to pack.
    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state;
        load_res = 1'b0;
        fin_exp  = exp_q;
        fin_man  = man_rnd;
`ifdef FPMUL_STATUS_EN
        fin_inexact = guard_b | sticky_b;
`endif
        unique case (state)
            IDLE:   if (accept) state_d = NORM;
            NORM:   state_d = ROUND;
            ROUND: begin
                if (carry) begin
                    state_d = RENORM;
                end else begin
                    state_d  = DONE;
                    load_res = 1'b1;
                end
            end
            RENORM: begin
                state_d  = DONE;
                load_res = 1'b1;
                fin_exp  = exp_q + EXP_W'(1);
                fin_man  = '0;
`ifdef FPMUL_STATUS_EN
                fin_inexact = gs_q;
`endif
            end
            DONE:   if (o_valid && i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result packing: zero, then overflow to Inf, then flush, then normal.
    always_comb begin
        ovf = !zero_q && ($signed(fin_exp) >= $signed(EMAX_V));
        unf = !zero_q && !ovf && ($signed(fin_exp) <= $signed(EXP_ZERO));
        if (zero_q)   res_d = {sign_q, 31'b0};
        else if (ovf) res_d = {sign_q, 8'hFF, 23'b0};
        else if (unf) res_d = {sign_q, 31'b0};
        else          res_d = {sign_q, fin_exp[7:0], fin_man};
`ifdef FPMUL_STATUS_EN
        flags_d = {fin_inexact | ovf | unf, ovf, unf, zero_q};
`endif
    end

    // Datapath registers and the registered output handshake.
    // NOTE: datapath registers reset too, so no stale operand is visible after an abort.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prod_q   <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            o_result <= '0;
            o_valid  <= 1'b0;
`ifdef FPMUL_STATUS_EN
            gs_q     <= 1'b0;
            o_flags  <= '0;
`endif
        end else begin
            if (accept) begin
                prod_q <= i_prod;
                exp_q  <= i_exp;
                sign_q <= i_sign;
            end
            if (state == NORM) begin
                prod_q <= prod_q << cnt;
                exp_q  <= exp_q + EXP_W'(1) - EXP_W'(cnt);
                zero_q <= (cnt == CNT_W'(PW));
            end
`ifdef FPMUL_STATUS_EN
            if (state == ROUND) gs_q <= guard_b | sticky_b;
`endif
            if (load_res) begin
                o_result <= res_d;
                o_valid  <= 1'b1;
`ifdef FPMUL_STATUS_EN
                o_flags  <= flags_d;
`endif
            end else if (o_valid && i_ready) begin
                o_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fpmul_norm_ctrl.sv
// tb_fpmul_norm_ctrl: scoreboard bench for fpmul_norm_ctrl. Expected results
// are pushed when an operand is accepted and popped when o_valid rises.
// Latency is counted in rising edges with the accept edge as edge 1.
module tb_fpmul_norm_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [47:0] i_prod;
    logic [9:0]  i_exp;
    logic        i_sign;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
`ifdef FPMUL_STATUS_EN
    logic [3:0]  o_flags;
`endif

    typedef struct {
        logic [31:0] result;
        logic [3:0]  flags;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    fpmul_norm_ctrl dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_prod   (i_prod),
        .i_exp    (i_exp),
        .i_sign   (i_sign),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result)
`ifdef FPMUL_STATUS_EN
        ,
        .o_flags  (o_flags)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp_v);
        end
    endtask

    // One operation: drive, push expectation at accept, wait bounded for o_valid,
    // pop and compare, optionally hold i_ready low, then confirm the handoff.
    task automatic run_op(input logic [47:0] prod, input logic [9:0] e, input logic s,
                          input logic [31:0] res, input logic [3:0] flg, input int lat,
                          input int hold);
        exp_t want;
        int   n;
        @(negedge i_clk);
        i_prod  = prod;
        i_exp   = e;
        i_sign  = s;
        i_valid = 1'b1;
        i_ready = (hold == 0);
        @(posedge i_clk);
        sb_q.push_back('{result: res, flags: flg, lat: lat});
        #1;
        i_valid = 1'b0;
        i_prod  = {$urandom, $urandom};
        i_exp   = 10'($urandom);
        i_sign  = 1'($urandom);
        check("busy_ready", {31'b0, o_ready}, 32'd0);
        n = 1;
        while (!o_valid && n < 20) begin
            @(posedge i_clk);
            n++;
            #1;
        end
        want = sb_q.pop_front();
        if (!o_valid) begin
            check("timeout", 32'd0, 32'd1);
            return;
        end
        check("result", o_result, want.result);
        check("latency", n, want.lat);
`ifdef FPMUL_STATUS_EN
        check("flags", {28'b0, o_flags}, {28'b0, want.flags});
`endif
        for (int h = 0; h < hold; h++) begin
            @(posedge i_clk);
            #1;
            check("hold_result", o_result, want.result);
            check("hold_ready", {31'b0, o_ready}, 32'd0);
            check("hold_valid", {31'b0, o_valid}, 32'd1);
        end
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("post_valid", {31'b0, o_valid}, 32'd0);
        check("post_ready", {31'b0, o_ready}, 32'd1);
    endtask

    initial begin
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_prod  = '0;
        i_exp   = '0;
        i_sign  = 1'b0;
        #1;
        check("rst_ready", {31'b0, o_ready}, 32'd1);
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_result", o_result, 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;

        //     prod             exp      sign  result        flags    lat hold
        run_op(48'h900000000000, 10'd127, 1'b0, 32'h40100000, 4'b0000, 3, 0);
        run_op(48'h400000000000, 10'd127, 1'b1, 32'hBF800000, 4'b0000, 3, 0);
        run_op(48'h7FFFFFC00000, 10'd127, 1'b0, 32'h40000000, 4'b1000, 4, 0);
        run_op(48'h900000000000, 10'd254, 1'b0, 32'h7F800000, 4'b1100, 3, 0);
        run_op(48'h900000000000, 10'h3FF, 1'b0, 32'h00000000, 4'b1010, 3, 0);
        run_op(48'h000000000000, 10'd127, 1'b1, 32'h80000000, 4'b0001, 3, 5);
        run_op(48'h800000800000, 10'd127, 1'b0, 32'h40000000, 4'b1000, 3, 0);
        run_op(48'h800001800000, 10'd127, 1'b0, 32'h40000002, 4'b1000, 3, 0);
        run_op(48'h800000C00000, 10'd127, 1'b0, 32'h40000001, 4'b1000, 3, 0);
        run_op(48'h000000000001, 10'd127, 1'b0, 32'h28800000, 4'b0000, 3, 0);
        run_op(48'h400000000000, 10'd1,   1'b0, 32'h00800000, 4'b0000, 3, 0);
        run_op(48'h400000000000, 10'd0,   1'b1, 32'h80000000, 4'b1010, 3, 0);
        run_op(48'h400000000000, 10'd254, 1'b0, 32'h7F000000, 4'b0000, 3, 1);
        run_op(48'h400000000000, 10'd255, 1'b0, 32'h7F800000, 4'b1100, 3, 0);
        run_op(48'h7FFFFFC00000, 10'd254, 1'b1, 32'hFF800000, 4'b1100, 4, 0);
        run_op(48'h400000000000, 10'h3FB, 1'b0, 32'h00000000, 4'b1010, 3, 0);

        // Abort in ROUND: the in-flight result is discarded.
        @(negedge i_clk);
        i_prod  = 48'h900000000000;
        i_exp   = 10'd127;
        i_sign  = 1'b0;
        i_valid = 1'b1;
        @(posedge i_clk);
        sb_q.push_back('{result: 32'h40100000, flags: 4'b0000, lat: 3});
        #1 i_valid = 1'b0;
        @(posedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        check("abort_valid", {31'b0, o_valid}, 32'd0);
        check("abort_ready", {31'b0, o_ready}, 32'd1);
        check("abort_result", o_result, 32'd0);
        void'(sb_q.pop_back());
        @(negedge i_clk);
        i_rst = 1'b0;
        run_op(48'h900000000000, 10'd127, 1'b0, 32'h40100000, 4'b0000, 3, 0);

        check("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
